// File: rtl/mag_cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// Covers the FSM state, the one-hot result encoding and the digit-count sizing.
package mag_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Result bit order is {gt, eq, lt}; all-zero means no result yet.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

  function automatic int unsigned mag_cmp_ndig(input int unsigned width,
                                               input int unsigned digit);
    return width / digit;
  endfunction

  function automatic int unsigned mag_cmp_idx_w(input int unsigned width,
                                                input int unsigned digit);
    int unsigned n;
    n = width / digit;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mag_cmp_digit.sv
// Combinational DIGIT-bit magnitude comparator.
// This is the generalised form of the original 2-bit comparator.
module mag_cmp_digit #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/mag_cmp_seq.sv
// Sequential MSB-first magnitude comparator with a start/done handshake.
// Define MAG_CMP_SIGNED_EN to add the is_signed port for two's-complement compares.
module mag_cmp_seq
  import mag_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MAG_CMP_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int unsigned NDIG  = mag_cmp_ndig(WIDTH, DIGIT);
  localparam int unsigned IDX_W = mag_cmp_idx_w(WIDTH, DIGIT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("mag_cmp_seq: WIDTH must be at least 2");
  end
  if ((DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
    $error("mag_cmp_seq: DIGIT must divide WIDTH");
  end

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [IDX_W-1:0] idx;
  logic [2:0]       res;
  logic [WIDTH-1:0] msb_flip;
  logic             d_gt;
  logic             d_eq;
  logic             d_lt;
  logic [2:0]       digit_res;

  // Flipping both MSBs maps two's-complement order onto unsigned order.
`ifdef MAG_CMP_SIGNED_EN
  assign msb_flip = {is_signed, {(WIDTH-1){1'b0}}};
`else
  assign msb_flip = '0;
`endif

  mag_cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (sa[WIDTH-1 -: DIGIT]),
    .b  (sb[WIDTH-1 -: DIGIT]),
    .gt (d_gt),
    .eq (d_eq),
    .lt (d_lt)
  );

  assign digit_res = {d_gt, d_eq, d_lt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      idx   <= '0;
      res   <= RES_NONE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            sa    <= a ^ msb_flip;
            sb    <= b ^ msb_flip;
            idx   <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          if ((digit_res != RES_EQ) || (idx == LAST_IDX)) begin
            state <= DONE;
            res   <= digit_res;
            done  <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            sa  <= sa << DIGIT;
            sb  <= sb << DIGIT;
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign {gt, eq, lt} = res;

endmodule

// File: tb/tb_mag_cmp_seq.sv
// Self-checking bench for mag_cmp_seq: DIGIT=1 and DIGIT=4 instances, directed and random compares.
// Expected results and latencies come from plain integer comparison and first-differing-digit rules.
module tb_mag_cmp_seq;

  logic       clk;
  logic       rst_n;
  logic       start_v [2];
  logic [7:0] a_v     [2];
  logic [7:0] b_v     [2];
  logic       sg_v    [2];
  logic       ready_v [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic       gt_v    [2];
  logic       eq_v    [2];
  logic       lt_v    [2];

  int         errors = 0;
  int         checks = 0;
  logic [2:0] prev   [2];
  int         last_s = 0;

`ifdef MAG_CMP_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mag_cmp_seq #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
`ifdef MAG_CMP_SIGNED_EN
    .is_signed(sg_v[0]),
`endif
    .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0])
  );

  mag_cmp_seq #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
`ifdef MAG_CMP_SIGNED_EN
    .is_signed(sg_v[1]),
`endif
    .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1])
  );

  function automatic int dig_of(input int s);
    return (s == 0) ? 1 : 4;
  endfunction

  // Index (0 = most significant) of the first digit where x and y differ; last digit if equal.
  function automatic int first_diff(input logic [7:0] x, input logic [7:0] y, input int dig);
    int diff;
    int nd;
    diff = int'(x) ^ int'(y);
    nd   = 8 / dig;
    for (int i = 0; i < nd; i++)
      if (((diff >> (8 - (i + 1) * dig)) & ((1 << dig) - 1)) != 0) return i;
    return nd - 1;
  endfunction

  function automatic logic [2:0] ref_res(input logic [7:0] x, input logic [7:0] y, input logic sg);
    int xi;
    int yi;
    xi = sg ? int'($signed(x)) : int'(x);
    yi = sg ? int'($signed(y)) : int'(y);
    if (xi > yi) return 3'b100;
    if (xi < yi) return 3'b001;
    return 3'b010;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_reset(input int s);
    chk("rst_ready", 32'(ready_v[s]), 32'd1);
    chk("rst_busy",  32'(busy_v[s]),  32'd0);
    chk("rst_done",  32'(done_v[s]),  32'd0);
    chk("rst_res",   32'({gt_v[s], eq_v[s], lt_v[s]}), 32'd0);
  endtask

  // Called at a negedge with DUT s ready; returns at the negedge of its DONE cycle.
  task automatic cmp(input int s, input logic [7:0] av, input logic [7:0] bv, input logic sg);
    int d;
    int n;
    int lim;
    logic [2:0] exp;
    d   = first_diff(av, bv, dig_of(s));
    exp = ref_res(av, bv, sg);
    lim = 8 / dig_of(s) + 3;
    chk("ready_before_start", 32'(ready_v[s]), 32'd1);
    a_v[s] = av; b_v[s] = bv; sg_v[s] = sg; start_v[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[s] = 1'b0;
    a_v[s] = 8'($urandom); b_v[s] = 8'($urandom); sg_v[s] = SGN_EN & 1'($urandom);
    chk("busy_after_start", 32'(busy_v[s]), 32'd1);
    n = 0;
    while (n < lim) begin
      @(negedge clk);
      n++;
      if (done_v[s]) break;
      chk("busy_run", 32'(busy_v[s]), 32'd1);
      chk("res_held_run", 32'({gt_v[s], eq_v[s], lt_v[s]}), 32'(prev[s]));
    end
    chk("latency", 32'(n), 32'(d + 1));
    chk("result", 32'({gt_v[s], eq_v[s], lt_v[s]}), 32'(exp));
    chk("ready_done", 32'(ready_v[s]), 32'd1);
    chk("busy_done",  32'(busy_v[s]),  32'd0);
    prev[s] = exp;
    last_s  = s;
  endtask

  task automatic idle(input int s);
    @(negedge clk);
    chk("done_pulse_len", 32'(done_v[s]), 32'd0);
    chk("ready_idle", 32'(ready_v[s]), 32'd1);
    chk("res_held_idle", 32'({gt_v[s], eq_v[s], lt_v[s]}), 32'(prev[s]));
  endtask

  initial begin
    logic [7:0] av;
    logic [7:0] bv;
    logic       sg;
    int         s;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0; sg_v[i] = 1'b0; prev[i] = '0;
    end
    rst_n = 1'b0;
    #12;
    chk_idle_reset(0);
    chk_idle_reset(1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    cmp(0, 8'hA5, 8'hA5, 1'b0); idle(0);
    cmp(0, 8'h80, 8'h7F, 1'b0); idle(0);
    if (SGN_EN) begin
      cmp(0, 8'h80, 8'h7F, 1'b1); idle(0);
    end
    cmp(0, 8'h12, 8'h13, 1'b0);
    cmp(0, 8'hFF, 8'h00, 1'b0); idle(0);

    // Second start mid-run must be ignored; reset mid-run discards everything.
    a_v[0] = 8'h01; b_v[0] = 8'h01; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) begin a_v[0] = 8'h80; b_v[0] = 8'h00; start_v[0] = 1'b1; end
      if (c == 4) start_v[0] = 1'b0;
      chk("busy_ignore", 32'(busy_v[0]), 32'd1);
      chk("done_ignore", 32'(done_v[0]), 32'd0);
      if (c < 5) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk_idle_reset(0);
    chk_idle_reset(1);
    prev[0] = '0; prev[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_queued_start", 32'({busy_v[0], done_v[0]}), 32'd0);
    end
    cmp(0, 8'h01, 8'h02, 1'b0); idle(0);

    cmp(1, 8'h3C, 8'h3D, 1'b0); idle(1);
    cmp(1, 8'h4C, 8'h3D, 1'b0);
    cmp(1, 8'h77, 8'h77, 1'b0); idle(1);

    for (int it = 0; it < 60; it++) begin
      s  = int'($urandom_range(0, 1));
      av = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       bv = av;
        1:       bv = av ^ 8'(1 << $urandom_range(0, 7));
        default: bv = 8'($urandom);
      endcase
      sg = SGN_EN & 1'($urandom);
      if ((s != last_s) || ($urandom_range(0, 1) == 0)) idle(last_s);
      cmp(s, av, bv, sg);
    end
    idle(last_s);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
